// File: rtl/calc_core.sv
// calc_core: keypad calculator core with accumulator, pending operator,
// entry argument, bit-serial restoring divider and sticky error state.
module calc_core #(
    parameter int WIDTH   = 10,
    parameter int ARG_MAX = 999
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic [3:0]       keycode,
    input  logic             key_pressed,
    output logic [WIDTH-1:0] display_value,
    output logic             error,
    output logic             busy,
    output logic [3:0]       state_dbg,
    output logic [7:0]       key_count
);

    typedef enum logic [3:0] {
        S_CLEAR    = 4'd0,
        S_IDLE     = 4'd1,
        S_DIGIT    = 4'd2,
        S_OP       = 4'd3,
        S_CALC     = 4'd4,
        S_DIVIDE   = 4'd5,
        S_SHOW_ARG = 4'd6,
        S_SHOW_RES = 4'd7,
        S_ERROR    = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        OP_PLUS  = 2'd0,
        OP_MINUS = 2'd1,
        OP_MUL   = 2'd2,
        OP_DIV   = 2'd3
    } op_t;

    localparam int                ARG_WIDE  = WIDTH + 4;
    localparam logic [ARG_WIDE-1:0] ARG_MAX_W = ARG_WIDE'(ARG_MAX);
    localparam logic [4:0]        DIV_LAST  = 5'(WIDTH - 1);

    state_t             state_r, state_nxt_s;
    logic [WIDTH-1:0]   acc_r, acc_nxt_s;
    logic [WIDTH-1:0]   arg_r, arg_nxt_s;
    op_t                op_r, op_nxt_s;
    op_t                op_next_r, op_next_nxt_s;
    logic               fresh_r, fresh_nxt_s;
    logic               key_prev_r;
    logic [3:0]         key_r, key_nxt_s;
    logic [WIDTH-1:0]   disp_r, disp_nxt_s;
    logic               error_r, error_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic [7:0]         key_count_r, key_count_nxt_s;
    logic [WIDTH-1:0]   rem_r, rem_nxt_s;
    logic [WIDTH-1:0]   quo_r, quo_nxt_s;
    logic [WIDTH-1:0]   divisor_r, divisor_nxt_s;
    logic [4:0]         div_cnt_r, div_cnt_nxt_s;

    // Datapath helpers shared by the next-state logic.
    logic                  key_edge_s;
    logic [ARG_WIDE-1:0]   arg_wide_s;
    logic [ARG_WIDE-1:0]   arg_x10_s;
    logic [WIDTH:0]        sum_s;
    logic [2*WIDTH-1:0]    prod_s;
    logic [WIDTH:0]        trial_s;
    logic [WIDTH:0]        trial_sub_s;
    logic                  trial_ge_s;
    logic [WIDTH-1:0]      rem_step_s;
    logic [WIDTH-1:0]      quo_step_s;

    assign key_edge_s  = key_pressed & ~key_prev_r;
    assign arg_wide_s  = {4'd0, arg_r};
    assign arg_x10_s   = (arg_wide_s << 3) + (arg_wide_s << 1) + {{WIDTH{1'b0}}, key_r};
    assign sum_s       = {1'b0, acc_r} + {1'b0, arg_r};
    assign prod_s      = {{WIDTH{1'b0}}, acc_r} * {{WIDTH{1'b0}}, arg_r};
    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    assign trial_s     = {rem_r, quo_r[WIDTH-1]};
    assign trial_ge_s  = (trial_s >= {1'b0, divisor_r});
    assign trial_sub_s = trial_s - {1'b0, divisor_r};
    assign rem_step_s  = trial_ge_s ? trial_sub_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
    assign quo_step_s  = {quo_r[WIDTH-2:0], trial_ge_s};

    // Next-state and next-register logic for the calculator FSM.
    always_comb begin
        state_nxt_s     = state_r;
        acc_nxt_s       = acc_r;
        arg_nxt_s       = arg_r;
        op_nxt_s        = op_r;
        op_next_nxt_s   = op_next_r;
        fresh_nxt_s     = fresh_r;
        key_nxt_s       = key_r;
        disp_nxt_s      = disp_r;
        error_nxt_s     = error_r;
        busy_nxt_s      = busy_r;
        key_count_nxt_s = key_count_r;
        rem_nxt_s       = rem_r;
        quo_nxt_s       = quo_r;
        divisor_nxt_s   = divisor_r;
        div_cnt_nxt_s   = div_cnt_r;

        case (state_r)
            S_CLEAR: begin
                acc_nxt_s     = '0;
                arg_nxt_s     = '0;
                disp_nxt_s    = '0;
                op_nxt_s      = OP_PLUS;
                op_next_nxt_s = OP_PLUS;
                error_nxt_s   = 1'b0;
                fresh_nxt_s   = 1'b0;
                busy_nxt_s    = 1'b0;
                state_nxt_s   = S_IDLE;
            end
            S_IDLE: begin
                if (key_edge_s) begin
                    key_count_nxt_s = key_count_r + 8'd1;
                    key_nxt_s       = keycode;
                    if (keycode <= 4'd9) begin
                        state_nxt_s = S_DIGIT;
                    end else if (keycode == 4'hC) begin
                        state_nxt_s = S_CLEAR;
                    end else begin
                        state_nxt_s = S_OP;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_DIGIT: begin
                if (fresh_r) begin
                    acc_nxt_s   = '0;
                    fresh_nxt_s = 1'b0;
                end else begin
                    fresh_nxt_s = fresh_r;
                end
                // Digits that would push the entry past the limit are dropped.
                if (arg_x10_s <= ARG_MAX_W) begin
                    arg_nxt_s = arg_x10_s[WIDTH-1:0];
                end else begin
                    arg_nxt_s = arg_r;
                end
                state_nxt_s = S_SHOW_ARG;
            end
            S_OP: begin
                case (key_r)
                    4'hB:    op_next_nxt_s = OP_MUL;
                    4'hD:    op_next_nxt_s = OP_DIV;
                    4'hF:    op_next_nxt_s = OP_MINUS;
                    default: op_next_nxt_s = OP_PLUS;
                endcase
                fresh_nxt_s = (key_r == 4'hA);
                state_nxt_s = S_CALC;
            end
            S_CALC: begin
                op_nxt_s  = op_next_r;
                arg_nxt_s = '0;
                case (op_r)
                    OP_PLUS: begin
                        if (sum_s[WIDTH]) begin
                            state_nxt_s = S_ERROR;
                        end else begin
                            acc_nxt_s   = sum_s[WIDTH-1:0];
                            state_nxt_s = S_SHOW_RES;
                        end
                    end
                    OP_MINUS: begin
                        if (arg_r > acc_r) begin
                            state_nxt_s = S_ERROR;
                        end else begin
                            acc_nxt_s   = acc_r - arg_r;
                            state_nxt_s = S_SHOW_RES;
                        end
                    end
                    OP_MUL: begin
                        if (prod_s[2*WIDTH-1:WIDTH] != '0) begin
                            state_nxt_s = S_ERROR;
                        end else begin
                            acc_nxt_s   = prod_s[WIDTH-1:0];
                            state_nxt_s = S_SHOW_RES;
                        end
                    end
                    OP_DIV: begin
                        if (arg_r == '0) begin
                            state_nxt_s = S_ERROR;
                        end else begin
                            divisor_nxt_s = arg_r;
                            quo_nxt_s     = acc_r;
                            rem_nxt_s     = '0;
                            div_cnt_nxt_s = DIV_LAST;
                            busy_nxt_s    = 1'b1;
                            state_nxt_s   = S_DIVIDE;
                        end
                    end
                    default: state_nxt_s = S_ERROR;
                endcase
            end
            S_DIVIDE: begin
                rem_nxt_s = rem_step_s;
                quo_nxt_s = quo_step_s;
                if (div_cnt_r == 5'd0) begin
                    acc_nxt_s   = quo_step_s;
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = S_SHOW_RES;
                end else begin
                    div_cnt_nxt_s = div_cnt_r - 5'd1;
                    busy_nxt_s    = 1'b1;
                end
            end
            S_SHOW_ARG: begin
                disp_nxt_s  = arg_r;
                state_nxt_s = S_IDLE;
            end
            S_SHOW_RES: begin
                disp_nxt_s  = acc_r;
                state_nxt_s = S_IDLE;
            end
            S_ERROR: begin
                error_nxt_s = 1'b1;
                disp_nxt_s  = '0;
                // Only clear leaves the error state; other keys are counted and dropped.
                if (key_edge_s) begin
                    key_count_nxt_s = key_count_r + 8'd1;
                    if (keycode == 4'hC) begin
                        state_nxt_s = S_CLEAR;
                    end else begin
                        state_nxt_s = S_ERROR;
                    end
                end else begin
                    state_nxt_s = S_ERROR;
                end
            end
            default: state_nxt_s = S_CLEAR;
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_CLEAR;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            acc_r       <= '0;
            arg_r       <= '0;
            op_r        <= OP_PLUS;
            op_next_r   <= OP_PLUS;
            fresh_r     <= 1'b0;
            key_prev_r  <= 1'b0;
            key_r       <= 4'd0;
            disp_r      <= '0;
            error_r     <= 1'b0;
            busy_r      <= 1'b0;
            key_count_r <= 8'd0;
            rem_r       <= '0;
            quo_r       <= '0;
            divisor_r   <= '0;
            div_cnt_r   <= 5'd0;
        end else begin
            acc_r       <= acc_nxt_s;
            arg_r       <= arg_nxt_s;
            op_r        <= op_nxt_s;
            op_next_r   <= op_next_nxt_s;
            fresh_r     <= fresh_nxt_s;
            key_prev_r  <= key_pressed;
            key_r       <= key_nxt_s;
            disp_r      <= disp_nxt_s;
            error_r     <= error_nxt_s;
            busy_r      <= busy_nxt_s;
            key_count_r <= key_count_nxt_s;
            rem_r       <= rem_nxt_s;
            quo_r       <= quo_nxt_s;
            divisor_r   <= divisor_nxt_s;
            div_cnt_r   <= div_cnt_nxt_s;
        end
    end

    assign display_value = disp_r;
    assign error         = error_r;
    assign busy          = busy_r;
    assign state_dbg     = state_r;
    assign key_count     = key_count_r;

endmodule

// File: tb/tb_calc_core.sv
// tb_calc_core: directed and random key sequences checked against a
// key-level arithmetic model of the calculator.
module tb_calc_core;

    localparam int WIDTH   = 10;
    localparam int ARG_MAX = 999;
    localparam int MAXV    = (1 << WIDTH) - 1;

    logic             Clk = 1'b0;
    logic             reset = 1'b0;
    logic [3:0]       keycode = 4'd0;
    logic             key_pressed = 1'b0;
    logic [WIDTH-1:0] display_value;
    logic             error;
    logic             busy;
    logic [3:0]       state_dbg;
    logic [7:0]       key_count;

    calc_core #(.WIDTH(WIDTH), .ARG_MAX(ARG_MAX)) dut (
        .Clk           (Clk),
        .reset         (reset),
        .keycode       (keycode),
        .key_pressed   (key_pressed),
        .display_value (display_value),
        .error         (error),
        .busy          (busy),
        .state_dbg     (state_dbg),
        .key_count     (key_count)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Key-level model: op 0=plus 1=minus 2=mul 3=div
    int m_acc, m_arg, m_op, m_fresh, m_err, m_disp, m_count;

    function automatic void model_clear();
        m_acc = 0; m_arg = 0; m_op = 0; m_fresh = 0; m_err = 0; m_disp = 0;
    endfunction

    function automatic void model_key(input int k);
        int r;
        int bad;
        m_count = (m_count + 1) % 256;
        if (m_err != 0) begin
            if (k == 12) model_clear();
        end else if (k <= 9) begin
            if (m_fresh != 0) begin
                m_acc = 0;
                m_fresh = 0;
            end
            if (m_arg * 10 + k <= ARG_MAX) m_arg = m_arg * 10 + k;
            m_disp = m_arg;
        end else if (k == 12) begin
            model_clear();
        end else begin
            bad = 0;
            r = m_acc;
            case (m_op)
                0: begin r = m_acc + m_arg; bad = (r > MAXV); end
                1: begin bad = (m_arg > m_acc); r = m_acc - m_arg; end
                2: begin r = m_acc * m_arg; bad = (r > MAXV); end
                default: begin bad = (m_arg == 0); if (m_arg != 0) r = m_acc / m_arg; end
            endcase
            case (k)
                11: m_op = 2;
                13: m_op = 3;
                15: m_op = 1;
                default: m_op = 0;
            endcase
            m_arg = 0;
            m_fresh = (k == 10);
            if (bad != 0) begin
                m_err = 1;
                m_disp = 0;
            end else begin
                m_acc = r;
                m_disp = r;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Press and release one key, then wait (bounded) until the core settles.
    task automatic press(input int k, output int bcyc, output int timeout);
        @(negedge Clk);
        keycode = 4'(k);
        key_pressed = 1'b1;
        bcyc = 0;
        repeat (2) begin
            @(negedge Clk);
            if (busy === 1'b1) bcyc++;
        end
        key_pressed = 1'b0;
        timeout = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (busy === 1'b1) bcyc++;
            if ((state_dbg === 4'd1 && busy === 1'b0) || (state_dbg === 4'd8 && error === 1'b1)) begin
                timeout = 0;
                break;
            end
        end
    endtask

    task automatic do_key(input int k);
        int bcyc;
        int to;
        int exp_div;
        exp_div = (m_err == 0 && k >= 10 && k != 12 && m_op == 3 && m_arg != 0) ? WIDTH : 0;
        press(k, bcyc, to);
        model_key(k);
        check("settle_timeout", 32'(to), 32'd0);
        check("display_value", 32'(display_value), 32'(m_disp));
        check("error", 32'(error), 32'(m_err));
        check("key_count", 32'(key_count), 32'(m_count));
        check("busy_cycles", 32'(bcyc), 32'(exp_div));
        check("state_dbg", 32'(state_dbg), (m_err != 0) ? 32'd8 : 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int to;
        int ops[5];
        int r;
        int k;
        ops[0] = 10; ops[1] = 11; ops[2] = 13; ops[3] = 14; ops[4] = 15;

        // Reset state
        #1;
        check("rst_display", 32'(display_value), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_count", 32'(key_count), 32'd0);
        @(negedge Clk);
        reset = 1'b1;
        model_clear();
        m_count = 0;
        @(negedge Clk);
        check("idle_after_reset", 32'(state_dbg), 32'd1);

        // 12 + 34 = 46
        do_key(1); do_key(2); do_key(14);
        check("plan1_after_E", 32'(display_value), 32'd12);
        do_key(3); do_key(4);
        check("plan1_after_4", 32'(display_value), 32'd34);
        do_key(10);
        check("plan1_result", 32'(display_value), 32'd46);
        check("plan1_count", 32'(key_count), 32'd6);

        // 5 - 7 underflow, F ignored, C clears
        do_key(5); do_key(15); do_key(7); do_key(14);
        check("plan2_error", 32'(error), 32'd1);
        do_key(15);
        check("plan2_still_error", 32'(error), 32'd1);
        do_key(12);
        check("plan2_cleared", 32'(error), 32'd0);

        // 200 * 6 overflow; 31 * 33 = 1023 fits
        do_key(2); do_key(0); do_key(0); do_key(11); do_key(6); do_key(14);
        check("plan3_overflow", 32'(error), 32'd1);
        do_key(12);
        do_key(3); do_key(1); do_key(11); do_key(3); do_key(3); do_key(14);
        check("plan3_max", 32'(display_value), 32'd1023);
        do_key(12);

        // 100 / 7 = 14; 9 / 0 error
        do_key(1); do_key(0); do_key(0); do_key(13); do_key(7); do_key(10);
        check("plan4_quotient", 32'(display_value), 32'd14);
        do_key(12);
        do_key(9); do_key(13); do_key(0); do_key(10);
        check("plan4_div0", 32'(error), 32'd1);
        do_key(12);

        // Entry limit and fresh after equals
        do_key(1); do_key(2); do_key(3); do_key(4);
        check("plan5_limit", 32'(display_value), 32'd123);
        do_key(10); do_key(5);
        check("plan5_fresh_digit", 32'(display_value), 32'd5);
        do_key(10);
        check("plan5_fresh_result", 32'(display_value), 32'd5);
        do_key(12);

        // Reset in the middle of a divide, key held across release
        do_key(1); do_key(0); do_key(0); do_key(13); do_key(7);
        @(negedge Clk);
        keycode = 4'hA;
        key_pressed = 1'b1;
        to = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (busy === 1'b1) begin
                to = 0;
                break;
            end
        end
        check("div_busy_seen", 32'(to), 32'd0);
        repeat (3) @(negedge Clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_display", 32'(display_value), 32'd0);
        check("mid_rst_count", 32'(key_count), 32'd0);
        check("mid_rst_state", 32'(state_dbg), 32'd0);
        check("mid_rst_error", 32'(error), 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        reset = 1'b1;
        repeat (5) @(negedge Clk);
        check("held_key_not_counted", 32'(key_count), 32'd0);
        check("held_key_idle", 32'(state_dbg), 32'd1);
        key_pressed = 1'b0;
        model_clear();
        m_count = 0;
        do_key(8);
        check("post_rst_digit", 32'(display_value), 32'd8);

        // Random key sequences
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 60) k = int'($urandom_range(0, 9));
            else if (r < 65) k = 12;
            else k = ops[$urandom_range(0, 4)];
            do_key(k);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
